// File: rtl/data_ram_arbiter_if.sv
// Requester-side bus for one port of the data RAM arbiter.
//   req/we/lock/addr/wdata : request fields, held stable until gnt
//   gnt                    : combinational accept
//   rvalid/rdata/err       : registered response, one cycle after gnt
// master = requester, slave = arbiter.
interface data_ram_arbiter_if #(
  parameter int N = 10,
  parameter int M = 32
);
  logic         req;
  logic         we;
  logic         lock;
  logic [N-1:0] addr;
  logic [M-1:0] wdata;
  logic         gnt;
  logic         rvalid;
  logic [M-1:0] rdata;
  logic         err;

  modport master (output req, we, lock, addr, wdata,
                  input  gnt, rvalid, rdata, err);
  modport slave  (input  req, we, lock, addr, wdata,
                  output gnt, rvalid, rdata, err);
endinterface

// File: rtl/data_ram_arbiter.sv
// Two-port round-robin arbiter/sequencer for a single-port data RAM
// (combinational read, synchronous write).
//   clk, rst          : clock, async active-low reset
//   r0, r1            : requester ports (r0 = load/store unit, r1 = debug/DMA)
//   ram_we/addr/wdata : RAM command, driven from the granted port
//   ram_rdata         : RAM combinational read data
// A granted access with lock=1 keeps the RAM for that port until it issues
// an access with lock=0. Misaligned accesses are answered with err=1,
// rdata=0 and leave both the RAM and the lock state untouched.

// Per-port response register: captures read data / error at the grant edge
// and holds them until the next response to the same port.
module data_ram_arbiter_rsp #(
  parameter int M = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         gnt,
  input  logic         mis,
  input  logic [M-1:0] ram_rdata,
  output logic         rvalid,
  output logic [M-1:0] rdata,
  output logic         err
);
  logic         rvalid_d, rvalid_q;
  logic [M-1:0] rdata_d, rdata_q;
  logic         err_d, err_q;

  always_comb begin
    rvalid_d = gnt;
    rdata_d  = rdata_q;
    err_d    = err_q;
    if (gnt) begin
      // pre-write word is returned on writes too, so a locked pair can swap
      rdata_d = mis ? '0 : ram_rdata;
      err_d   = mis;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;
  assign err    = err_q;
endmodule

module data_ram_arbiter #(
  parameter int N = 10,
  parameter int M = 32
) (
  input  logic                clk,
  input  logic                rst,
  data_ram_arbiter_if.slave   r0,
  data_ram_arbiter_if.slave   r1,
  output logic                ram_we,
  output logic [N-1:0]        ram_addr,
  output logic [M-1:0]        ram_wdata,
  input  logic [M-1:0]        ram_rdata
);
  localparam int NP = 2;

  typedef enum logic [1:0] {UNLOCKED, LOCK0, LOCK1} state_e;

  state_e state_d, state_q;
  logic   last_d, last_q;

  logic [NP-1:0]        req, we, lock, gnt;
  logic [NP-1:0][N-1:0] addr;
  logic [NP-1:0][M-1:0] wdata;
  logic [NP-1:0][M-1:0] rdata;
  logic [NP-1:0]        rvalid, err;
  logic                 sel, mis;

  assign req   = {r1.req,   r0.req};
  assign we    = {r1.we,    r0.we};
  assign lock  = {r1.lock,  r0.lock};
  assign addr  = {r1.addr,  r0.addr};
  assign wdata = {r1.wdata, r0.wdata};

  always_comb begin
    gnt = '0;
    unique case (state_q)
      LOCK0:   gnt[0] = req[0];
      LOCK1:   gnt[1] = req[1];
      default: begin
        if (&req) gnt = last_q ? 2'b01 : 2'b10;
        else      gnt = req;
      end
    endcase

    // sel falls back to port 0 when idle, which is what ram_addr shows then
    sel = gnt[1];
    mis = (addr[sel][1:0] != 2'b00);

    state_d = state_q;
    last_d  = last_q;
    if (|gnt) begin
      last_d = sel;
      if (!mis) begin
        if (lock[sel]) state_d = sel ? LOCK1 : LOCK0;
        else           state_d = UNLOCKED;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= UNLOCKED;
      last_q  <= 1'b1;          // port 0 wins the first contention
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  assign ram_addr  = addr[sel];
  assign ram_wdata = wdata[sel];
  assign ram_we    = rst & (|gnt) & we[sel] & ~mis;

  for (genvar i = 0; i < NP; i++) begin : g_rsp
    data_ram_arbiter_rsp #(.M(M)) u_rsp (
      .clk      (clk),
      .rst      (rst),
      .gnt      (gnt[i]),
      .mis      (mis),
      .ram_rdata(ram_rdata),
      .rvalid   (rvalid[i]),
      .rdata    (rdata[i]),
      .err      (err[i])
    );
  end

  assign r0.gnt    = gnt[0];
  assign r1.gnt    = gnt[1];
  assign r0.rvalid = rvalid[0];
  assign r1.rvalid = rvalid[1];
  assign r0.rdata  = rdata[0];
  assign r1.rdata  = rdata[1];
  assign r0.err    = err[0];
  assign r1.err    = err[1];
endmodule

// File: tb/tb_data_ram_arbiter.sv
module tb_data_ram_arbiter;
  localparam int N = 10;
  localparam int M = 32;

  typedef struct {
    logic         err;
    logic [M-1:0] rdata;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  data_ram_arbiter_if #(.N(N), .M(M)) r0 ();
  data_ram_arbiter_if #(.N(N), .M(M)) r1 ();

  logic         ram_we;
  logic [N-1:0] ram_addr;
  logic [M-1:0] ram_wdata, ram_rdata;

  data_ram_arbiter #(.N(N), .M(M)) dut (
    .clk(clk), .rst(rst), .r0(r0), .r1(r1),
    .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // RAM with a backdoor load port
  logic [M-1:0] mem [256];
  logic         bd_we = 1'b0;
  logic [7:0]   bd_idx = '0;
  logic [M-1:0] bd_data = '0;
  always @(posedge clk) begin
    if (bd_we)       mem[bd_idx] <= bd_data;
    else if (ram_we) mem[ram_addr[N-1:2]] <= ram_wdata;
  end
  assign ram_rdata = mem[ram_addr[N-1:2]];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [M-1:0] got, input logic [M-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // reference model
  logic [M-1:0] ref_mem [256];
  int           mst;            // 0 unlocked, 1 lock0, 2 lock1
  logic         mlast;
  logic [1:0]   pend, eg;
  rsp_t         q0[$], q1[$];
  logic [M-1:0] hold_rd [2];
  logic         hold_err [2];

  wire [1:0] req_v  = {r1.req,    r0.req};
  wire [1:0] we_v   = {r1.we,     r0.we};
  wire [1:0] lock_v = {r1.lock,   r0.lock};
  wire [1:0] gnt_v  = {r1.gnt,    r0.gnt};
  wire [1:0] rv_v   = {r1.rvalid, r0.rvalid};
  wire [1:0] err_v  = {r1.err,    r0.err};
  wire [N-1:0] addr_v [2];
  wire [M-1:0] wd_v [2];
  wire [M-1:0] rd_v [2];
  assign addr_v[0] = r0.addr;  assign addr_v[1] = r1.addr;
  assign wd_v[0]   = r0.wdata; assign wd_v[1]   = r1.wdata;
  assign rd_v[0]   = r0.rdata; assign rd_v[1]   = r1.rdata;

  always @(negedge clk) begin
    rsp_t e;
    int   s;
    logic m;
    if (!rst) begin
      mst = 0; mlast = 1'b1; pend = '0;
      q0.delete(); q1.delete();
      for (int p = 0; p < 2; p++) begin
        hold_rd[p] = '0; hold_err[p] = 1'b0;
        chk($sformatf("rst_rvalid%0d", p), {31'b0, rv_v[p]}, 0);
        chk($sformatf("rst_err%0d", p),    {31'b0, err_v[p]}, 0);
        chk($sformatf("rst_rdata%0d", p),  rd_v[p], 0);
      end
      chk("rst_ram_we", {31'b0, ram_we}, 0);
    end else begin
      for (int p = 0; p < 2; p++) begin
        chk($sformatf("rvalid%0d", p), {31'b0, rv_v[p]}, {31'b0, pend[p]});
        if (pend[p]) begin
          s = (p == 0) ? q0.size() : q1.size();
          chk($sformatf("q_nonempty%0d", p), s, 1);
          if (s > 0) begin
            e = (p == 0) ? q0.pop_front() : q1.pop_front();
            hold_rd[p] = e.rdata; hold_err[p] = e.err;
          end
        end
        chk($sformatf("rdata%0d", p), rd_v[p], hold_rd[p]);
        chk($sformatf("err%0d", p), {31'b0, err_v[p]}, {31'b0, hold_err[p]});
      end
    end

    // expected grant for the current cycle
    eg = '0;
    if (mst == 1)      eg[0] = req_v[0];
    else if (mst == 2) eg[1] = req_v[1];
    else if (req_v == 2'b11) eg[mlast ? 0 : 1] = 1'b1;
    else eg = req_v;
    chk("gnt0", {31'b0, gnt_v[0]}, {31'b0, eg[0]});
    chk("gnt1", {31'b0, gnt_v[1]}, {31'b0, eg[1]});

    if (rst) begin
      pend = eg;
      if (eg == 2'b00) chk("ram_we_idle", {31'b0, ram_we}, 0);
      for (int p = 0; p < 2; p++) begin
        if (eg[p]) begin
          m = (addr_v[p][1:0] != 2'b00);
          chk("ram_addr", {22'b0, ram_addr}, {22'b0, addr_v[p]});
          chk("ram_we", {31'b0, ram_we}, {31'b0, we_v[p] & ~m});
          if (we_v[p] && !m) chk("ram_wdata", ram_wdata, wd_v[p]);
          e.err   = m;
          e.rdata = m ? '0 : ref_mem[addr_v[p][N-1:2]];
          if (p == 0) q0.push_back(e); else q1.push_back(e);
          if (we_v[p] && !m) ref_mem[addr_v[p][N-1:2]] = wd_v[p];
          mlast = p[0];
          if (!m) mst = lock_v[p] ? p + 1 : 0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input int p, input logic req, input logic we, input logic lock,
                     input logic [N-1:0] addr, input logic [M-1:0] wd);
    if (p == 0) begin
      r0.req = req; r0.we = we; r0.lock = lock; r0.addr = addr; r0.wdata = wd;
    end else begin
      r1.req = req; r1.we = we; r1.lock = lock; r1.addr = addr; r1.wdata = wd;
    end
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, '0, '0);
    drv(1, 0, 0, 0, '0, '0);
  endtask

  int         widx [8] = '{4, 8, 255, 0, 1, 2, 3, 100};
  logic [M-1:0] wval [8] = '{32'hDEADBEEF, 32'd5, 32'h11112222, 32'h0A0A0A0A,
                            32'h01010101, 32'h02020202, 32'h03030303, 32'h64646464};

  initial begin
    logic [1:0]   act;
    logic [N-1:0] a;
    idle();
    #1;
    // preload RAM and model while in reset
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    for (int i = 0; i < 8; i++) begin
      bd_we = 1'b1; bd_idx = widx[i][7:0]; bd_data = wval[i];
      ref_mem[widx[i]] = wval[i];
      step();
    end
    bd_we = 1'b0;
    step();
    rst = 1'b1;
    step();

    // single read
    drv(0, 1, 0, 0, 10'h010, '0); step(); idle(); step();

    // contention, 4 cycles
    drv(0, 1, 0, 0, 10'h010, '0); drv(1, 1, 0, 0, 10'h020, '0);
    repeat (4) step();
    idle(); step();

    // atomic swap by port 1
    drv(1, 1, 0, 1, 10'h020, '0); step();
    drv(1, 0, 0, 0, '0, '0); drv(0, 1, 0, 0, 10'h010, '0); step();
    drv(1, 1, 1, 0, 10'h020, 32'd9); step();
    drv(1, 0, 0, 0, '0, '0); step();
    idle(); step();
    chk("swap_mem", mem[8], 32'd9);

    // misaligned locked write, then port 1 must still get in
    drv(0, 1, 1, 1, 10'h013, 32'h1234); step();
    drv(0, 0, 0, 0, '0, '0); drv(1, 1, 0, 0, 10'h010, '0); step();
    idle(); step();
    chk("mis_mem", mem[4], 32'hDEADBEEF);

    // write-then-read at top word
    drv(0, 1, 1, 0, 10'h3FC, 32'hA5A5A5A5); step();
    drv(0, 1, 0, 0, 10'h3FC, '0); step();
    idle(); step();
    chk("wr_mem", mem[255], 32'hA5A5A5A5);

    // reset while port 0 holds the lock
    drv(0, 1, 0, 1, 10'h010, '0); step();
    drv(1, 1, 0, 0, 10'h020, '0);
    rst = 1'b0; step();
    rst = 1'b1; step();
    step();
    idle(); step();

    // random traffic
    act = '0;
    for (int c = 0; c < 300; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!act[p] || eg[p]) begin
          act[p] = ($urandom_range(0, 2) != 0);
          a = {widx[$urandom_range(0, 7)][7:0], 2'b00};
          if ($urandom_range(0, 5) == 0) a[1:0] = 2'($urandom_range(1, 3));
          drv(p, act[p], 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), a, $urandom);
        end
      end
      step();
    end
    idle();
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
